// File: rtl/ddr3_sched_pkg.sv
`default_nettype none
// ============================================================================
// Module   : ddr3_sched_pkg
// Purpose  : Shared opcode/state encodings and default DDR3 timing values.
// Revision : 1.0 - initial release
// ============================================================================
package ddr3_sched_pkg;

    typedef enum logic [1:0] {
        OP_ACT = 2'b00,
        OP_RD  = 2'b01,
        OP_WR  = 2'b10,
        OP_PRE = 2'b11
    } cmd_op_t;

    typedef enum logic [2:0] {
        S_IDLE     = 3'd0,
        S_ACT_WAIT = 3'd1,
        S_ROW_OPEN = 3'd2,
        S_RD_WAIT  = 3'd3,
        S_WR_WAIT  = 3'd4,
        S_BURST    = 3'd5,
        S_WR_RECOV = 3'd6,
        S_PRE_WAIT = 3'd7
    } sched_state_t;

    localparam int c_T_RCD   = 5;
    localparam int c_T_RP    = 5;
    localparam int c_T_RAS   = 15;
    localparam int c_T_CL    = 5;
    localparam int c_T_CWL   = 5;
    localparam int c_T_WR    = 6;
    localparam int c_T_BURST = 4;

endpackage
`default_nettype wire

// File: rtl/delay_timer.sv
`default_nettype none
// ============================================================================
// Module   : delay_timer
// Purpose  : Loadable saturating down-counter; done flags the last cycle.
// Revision : 1.0 - initial release
// ============================================================================
module delay_timer #(
    parameter int CNT_W = 8
) (
    input  logic             clock,
    input  logic             reset_n,
    input  logic             load,
    input  logic [CNT_W-1:0] load_val,
    output logic             done
);

    logic [CNT_W-1:0] r_remain;

    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            r_remain <= '0;
        end else if (load) begin
            r_remain <= load_val;
        end else if (r_remain != '0) begin
            r_remain <= r_remain - CNT_W'(1);
        end
    end

    // Loaded with N on the entry edge, so remaining==1 marks the Nth cycle.
    assign done = (r_remain == CNT_W'(1));

endmodule
`default_nettype wire

// File: rtl/ddr3_cmd_timing_scheduler.sv
`default_nettype none
// ============================================================================
// Module   : ddr3_cmd_timing_scheduler
// Purpose  : Single-bank DDR3 command scheduler enforcing tRCD/CL/CWL/tWR/tRAS/tRP.
// Revision : 1.0 - initial release
// ============================================================================
module ddr3_cmd_timing_scheduler
    import ddr3_sched_pkg::*;
#(
    parameter int T_RCD   = c_T_RCD,
    parameter int T_RP    = c_T_RP,
    parameter int T_RAS   = c_T_RAS,
    parameter int T_CL    = c_T_CL,
    parameter int T_CWL   = c_T_CWL,
    parameter int T_WR    = c_T_WR,
    parameter int T_BURST = c_T_BURST,
    parameter int ROW_W   = 15,
    parameter int COL_W   = 10,
    parameter int CNT_W   = 8
) (
    input  logic             clock,
    input  logic             reset_n,
    input  logic             cmd_valid,
    output logic             cmd_ready,
    input  logic [1:0]       cmd_op,
    input  logic [ROW_W-1:0] cmd_row,
    input  logic [COL_W-1:0] cmd_col,
    output logic             issue_valid,
    output logic [1:0]       issue_op,
    output logic [ROW_W-1:0] issue_row,
    output logic [COL_W-1:0] issue_col,
    output logic             data_phase,
    output logic             data_is_wr,
    output logic             row_open,
    output logic [ROW_W-1:0] open_row,
    output logic             err_illegal
);

    if (T_RCD < 1 || T_RCD >= (1 << CNT_W) || T_RP  < 1 || T_RP  >= (1 << CNT_W) ||
        T_RAS < 1 || T_RAS >= (1 << CNT_W) || T_CL  < 1 || T_CL  >= (1 << CNT_W) ||
        T_CWL < 1 || T_CWL >= (1 << CNT_W) || T_WR  < 1 || T_WR  >= (1 << CNT_W) ||
        T_BURST < 1 || T_BURST >= (1 << CNT_W)) begin : g_bad_timing
        $error("ddr3_cmd_timing_scheduler: every T_* must be in [1, 2**CNT_W)");
    end

    localparam logic [CNT_W-1:0] c_LD_RCD   = CNT_W'(T_RCD);
    localparam logic [CNT_W-1:0] c_LD_RP    = CNT_W'(T_RP);
    localparam logic [CNT_W-1:0] c_LD_RAS   = CNT_W'(T_RAS);
    localparam logic [CNT_W-1:0] c_LD_CL    = CNT_W'(T_CL);
    localparam logic [CNT_W-1:0] c_LD_CWL   = CNT_W'(T_CWL);
    localparam logic [CNT_W-1:0] c_LD_WR    = CNT_W'(T_WR);
    localparam logic [CNT_W-1:0] c_LD_BURST = CNT_W'(T_BURST);

    sched_state_t     r_state;
    sched_state_t     w_state_nxt;
    cmd_op_t          w_op;
    logic             r_live;
    logic             r_is_wr;
    logic [CNT_W-1:0] r_ras_cnt;
    logic             w_ras_ok;
    logic             w_ready;
    logic             w_accept;
    logic             w_legal;
    logic             w_issue;
    logic             w_load;
    logic [CNT_W-1:0] w_load_val;
    logic             w_timer_done;

    delay_timer #(
        .CNT_W    (CNT_W)
    ) u_state_timer (
        .clock    (clock),
        .reset_n  (reset_n),
        .load     (w_load),
        .load_val (w_load_val),
        .done     (w_timer_done)
    );

    always_comb begin
        w_op        = cmd_op_t'(cmd_op);
        w_ras_ok    = (r_ras_cnt >= c_LD_RAS);
        // PRE is stalled rather than rejected until tRAS has elapsed.
        w_ready     = r_live && ((r_state == S_IDLE) ||
                      ((r_state == S_ROW_OPEN) && ((w_op != OP_PRE) || w_ras_ok)));
        w_accept    = cmd_valid && w_ready;
        w_legal     = (r_state == S_IDLE) ? (w_op == OP_ACT) : (w_op != OP_ACT);
        w_issue     = w_accept && w_legal;
        w_state_nxt = r_state;
        w_load      = 1'b0;
        w_load_val  = '0;
        case (r_state)
            S_IDLE: begin
                if (w_issue) begin
                    w_state_nxt = S_ACT_WAIT;
                    w_load      = 1'b1;
                    w_load_val  = c_LD_RCD;
                end
            end
            S_ROW_OPEN: begin
                if (w_issue) begin
                    w_load = 1'b1;
                    case (w_op)
                        OP_RD: begin
                            w_state_nxt = S_RD_WAIT;
                            w_load_val  = c_LD_CL;
                        end
                        OP_WR: begin
                            w_state_nxt = S_WR_WAIT;
                            w_load_val  = c_LD_CWL;
                        end
                        default: begin
                            w_state_nxt = S_PRE_WAIT;
                            w_load_val  = c_LD_RP;
                        end
                    endcase
                end
            end
            S_ACT_WAIT: begin
                if (w_timer_done) w_state_nxt = S_ROW_OPEN;
            end
            S_RD_WAIT, S_WR_WAIT: begin
                if (w_timer_done) begin
                    w_state_nxt = S_BURST;
                    w_load      = 1'b1;
                    w_load_val  = c_LD_BURST;
                end
            end
            S_BURST: begin
                if (w_timer_done) begin
                    if (r_is_wr) begin
                        w_state_nxt = S_WR_RECOV;
                        w_load      = 1'b1;
                        w_load_val  = c_LD_WR;
                    end else begin
                        w_state_nxt = S_ROW_OPEN;
                    end
                end
            end
            S_WR_RECOV: begin
                if (w_timer_done) w_state_nxt = S_ROW_OPEN;
            end
            S_PRE_WAIT: begin
                if (w_timer_done) w_state_nxt = S_IDLE;
            end
            default: w_state_nxt = S_IDLE;
        endcase
    end

    assign cmd_ready = w_ready;

    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            r_state     <= S_IDLE;
            r_live      <= 1'b0;
            r_is_wr     <= 1'b0;
            r_ras_cnt   <= '0;
            issue_valid <= 1'b0;
            issue_op    <= 2'b00;
            issue_row   <= '0;
            issue_col   <= '0;
            data_phase  <= 1'b0;
            data_is_wr  <= 1'b0;
            row_open    <= 1'b0;
            open_row    <= '0;
            err_illegal <= 1'b0;
        end else begin
            r_state     <= w_state_nxt;
            r_live      <= 1'b1;
            issue_valid <= w_issue;
            issue_op    <= w_issue ? cmd_op : 2'b00;
            issue_row   <= !w_issue ? '0 : ((w_op == OP_ACT) ? cmd_row : open_row);
            issue_col   <= (w_issue && (w_op == OP_RD || w_op == OP_WR)) ? cmd_col : '0;
            err_illegal <= w_accept && !w_legal;
            data_phase  <= (w_state_nxt == S_BURST);
            data_is_wr  <= (w_state_nxt == S_BURST) && r_is_wr;

            if (w_issue && w_op == OP_ACT) begin
                row_open  <= 1'b1;
                open_row  <= cmd_row;
                r_ras_cnt <= '0;
            end else if (r_ras_cnt != '1) begin
                r_ras_cnt <= r_ras_cnt + CNT_W'(1);
            end

            if (w_issue && w_op == OP_PRE) row_open <= 1'b0;
            if (w_issue && (w_op == OP_RD || w_op == OP_WR)) r_is_wr <= (w_op == OP_WR);
        end
    end

endmodule
`default_nettype wire
